// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//
// Issue stage in front of the 32-bit shifter. For every accepted instruction it
// decodes the shift function, picks the shift amount (shamt field or the low
// bits of the resolved rs), resolves rs/rt against the EX/MEM and MEM/WB
// forwarding paths and captures the resulting operand triple. Captured entries
// are handed to the shifter through a 2-entry skid buffer, so a stalled
// shifter never causes an instruction to be lost.
//
// Optional feature macro: SHIFT_ISSUE_FWD_EN
//   defined   - forwarding muxes on rs/rt are active (EX/MEM beats MEM/WB,
//               register index 0 is never forwarded)
//   undefined - rs/rt come straight from the register-file values; the
//               exmem_* / memwb_* ports are present but ignored
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake from decode
//   in_funct, in_shamt    MIPS funct and shamt fields
//   in_rs_idx/in_rs_val   rs register index and register-file value
//   in_rt_idx/in_rt_val   rt register index and register-file value
//   in_rd                 destination register, passed through
//   exmem_wen/rd/data     EX/MEM write-back forwarding source
//   memwb_wen/rd/data     MEM/WB write-back forwarding source
//   sh_valid / sh_ready   downstream handshake to the shifter
//   sh_a                  value to shift (resolved rt)
//   sh_b                  zero-extended shift amount
//   sh_sel                funct forwarded to the shifter
//   sh_rd                 destination register
//   sh_illegal            entry carries an unsupported funct
// -----------------------------------------------------------------------------
module shift_issue_stage #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_rs_idx,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [4:0]        in_rt_idx,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [4:0]        in_rd,
    input  logic              exmem_wen,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wen,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              sh_valid,
    input  logic              sh_ready,
    output logic [DATA_W-1:0] sh_a,
    output logic [DATA_W-1:0] sh_b,
    output logic [5:0]        sh_sel,
    output logic [4:0]        sh_rd,
    output logic              sh_illegal
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [AMT_W-1:0]  amt;
        logic [5:0]        sel;
        logic [4:0]        rd;
        logic              ill;
    } entry_t;

    // ------------------------------------------------------------------
    // Operand resolution: element 0 is rs, element 1 is rt.
    // ------------------------------------------------------------------
    logic [4:0]        op_idx [2];
    logic [DATA_W-1:0] op_rf  [2];
    logic [DATA_W-1:0] op_res [2];

    assign op_idx[0] = in_rs_idx;
    assign op_idx[1] = in_rt_idx;
    assign op_rf[0]  = in_rs_val;
    assign op_rf[1]  = in_rt_val;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef SHIFT_ISSUE_FWD_EN
            logic hit_exmem;
            logic hit_memwb;
            // $zero is hard-wired, so a write targeting index 0 never forwards.
            assign hit_exmem = exmem_wen && (exmem_rd == op_idx[gi]) && (op_idx[gi] != 5'd0);
            assign hit_memwb = memwb_wen && (memwb_rd == op_idx[gi]) && (op_idx[gi] != 5'd0);
            // EX/MEM is the younger producer, so it takes priority.
            assign op_res[gi] = hit_exmem ? exmem_data :
                                hit_memwb ? memwb_data : op_rf[gi];
`else
            assign op_res[gi] = op_rf[gi];
`endif
        end
    endgenerate

`ifndef SHIFT_ISSUE_FWD_EN
    // Forwarding sources are intentionally ignored in this build.
    logic unused_fwd;
    assign unused_fwd = ^{exmem_wen, exmem_rd, exmem_data, memwb_wen, memwb_rd, memwb_data};
`endif

    // Only the low AMT_W bits of rs ever act as a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^op_res[0][DATA_W-1:AMT_W];

    // ------------------------------------------------------------------
    // Function decode for the entry captured this cycle
    // ------------------------------------------------------------------
    entry_t dec_d;

    always_comb begin
        dec_d     = '0;
        dec_d.a   = op_res[1];
        dec_d.sel = in_funct;
        dec_d.rd  = in_rd;
        case (in_funct)
            6'b000000, 6'b000010, 6'b000011: dec_d.amt = AMT_W'(in_shamt);
            6'b000100, 6'b000110, 6'b000111: dec_d.amt = op_res[0][AMT_W-1:0];
            // Unsupported functions still flow downstream, flagged, with a zero amount.
            default: begin
                dec_d.amt = '0;
                dec_d.ill = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skid buffer FSM. out_q drives the shifter; skid_q holds the entry
    // that arrived while the shifter was stalled and is always older than
    // anything still upstream.
    // ------------------------------------------------------------------
    state_t state_q;
    entry_t out_q;
    entry_t skid_q;
    logic   in_ready_q;
    logic   sh_valid_q;
    logic   accept;

    assign accept = in_valid && in_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            sh_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_q      <= dec_d;
                        state_q    <= S_ONE;
                        sh_valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && sh_ready) begin
                        // Consume and refill in the same cycle: no bubble.
                        out_q <= dec_d;
                    end else if (accept) begin
                        skid_q     <= dec_d;
                        state_q    <= S_FULL;
                        in_ready_q <= 1'b0;
                    end else if (sh_ready) begin
                        state_q    <= S_EMPTY;
                        sh_valid_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (sh_ready) begin
                        out_q      <= skid_q;
                        state_q    <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_EMPTY;
                    in_ready_q <= 1'b1;
                    sh_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign sh_valid   = sh_valid_q;
    assign sh_a       = out_q.a;
    assign sh_b       = {{(DATA_W-AMT_W){1'b0}}, out_q.amt};
    assign sh_sel     = out_q.sel;
    assign sh_rd      = out_q.rd;
    assign sh_illegal = out_q.ill;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

`ifdef SHIFT_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [4:0]  in_rs_idx;
    logic [31:0] in_rs_val;
    logic [4:0]  in_rt_idx;
    logic [31:0] in_rt_val;
    logic [4:0]  in_rd;
    logic        exmem_wen;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        memwb_wen;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        sh_valid;
    logic        sh_ready;
    logic [31:0] sh_a;
    logic [31:0] sh_b;
    logic [5:0]  sh_sel;
    logic [4:0]  sh_rd;
    logic        sh_illegal;

    shift_issue_stage #(.DATA_W(32), .AMT_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_shamt(in_shamt),
        .in_rs_idx(in_rs_idx), .in_rs_val(in_rs_val),
        .in_rt_idx(in_rt_idx), .in_rt_val(in_rt_val),
        .in_rd(in_rd),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .sh_valid(sh_valid), .sh_ready(sh_ready),
        .sh_a(sh_a), .sh_b(sh_b), .sh_sel(sh_sel), .sh_rd(sh_rd),
        .sh_illegal(sh_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  sel;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs_idx;
        logic [31:0] rs_val;
        logic [4:0]  rt_idx;
        logic [31:0] rt_val;
        logic [4:0]  rd;
        logic        exwen;
        logic [4:0]  exrd;
        logic [31:0] exdata;
        logic        wbwen;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_ill;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    exp_t        q[$];
    logic [4:0]  popped[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: an operand reads the newest pending write to its register,
    // except $zero, which always reads as the register-file value.
    function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf);
        if (FWD && idx != 0 && exmem_wen && exmem_rd == idx) return exmem_data;
        if (FWD && idx != 0 && memwb_wen && memwb_rd == idx) return memwb_data;
        return rf;
    endfunction

    function automatic exp_t model_entry();
        exp_t e;
        logic [31:0] rs;
        rs    = resolve(in_rs_idx, in_rs_val);
        e.a   = resolve(in_rt_idx, in_rt_val);
        e.sel = in_funct;
        e.rd  = in_rd;
        e.ill = 1'b0;
        if (in_funct inside {6'd0, 6'd2, 6'd3})      e.b = 32'(in_shamt);
        else if (in_funct inside {6'd4, 6'd6, 6'd7}) e.b = rs % 32;
        else begin
            e.b   = 32'd0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // One clock: compare at the falling edge against the model queue,
    // then advance the model at the rising edge. Returns at posedge+1.
    task automatic cycle_check(output bit acc);
        bit cons;
        @(negedge clk);
        chk("sh_valid", 64'(sh_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("sh_a",       64'(sh_a),       64'(q[0].a));
            chk("sh_b",       64'(sh_b),       64'(q[0].b));
            chk("sh_sel",     64'(sh_sel),     64'(q[0].sel));
            chk("sh_rd",      64'(sh_rd),      64'(q[0].rd));
            chk("sh_illegal", 64'(sh_illegal), 64'(q[0].ill));
        end
        acc  = in_valid && (q.size() < 2);
        cons = (q.size() > 0) && sh_ready;
        if (cons) begin
            popped.push_back(sh_rd);
            $display("tx rd=%0d a=%h b=%h sel=%b ill=%b", sh_rd, sh_a, sh_b, sh_sel, sh_illegal);
        end
        @(posedge clk);
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(model_entry());
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        in_funct   = v.funct;   in_shamt  = v.shamt;
        in_rs_idx  = v.rs_idx;  in_rs_val = v.rs_val;
        in_rt_idx  = v.rt_idx;  in_rt_val = v.rt_val;
        in_rd      = v.rd;
        exmem_wen  = v.exwen;   exmem_rd  = v.exrd;  exmem_data = v.exdata;
        memwb_wen  = v.wbwen;   memwb_rd  = v.wbrd;  memwb_data = v.wbdata;
    endtask

    function automatic vec_t mk(input logic [5:0] f, input logic [4:0] sa,
                                input logic [4:0] rsi, input logic [31:0] rsv,
                                input logic [4:0] rti, input logic [31:0] rtv,
                                input logic [4:0] rd,
                                input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                input logic ww, input logic [4:0] wr, input logic [31:0] wd,
                                input logic [31:0] ea, input logic [31:0] eb, input logic ei);
        vec_t v;
        v.funct = f;  v.shamt = sa; v.rs_idx = rsi; v.rs_val = rsv;
        v.rt_idx = rti; v.rt_val = rtv; v.rd = rd;
        v.exwen = ew; v.exrd = er; v.exdata = ed;
        v.wbwen = ww; v.wbrd = wr; v.wbdata = wd;
        v.exp_a = ea; v.exp_b = eb; v.exp_ill = ei;
        return v;
    endfunction

    initial begin
        vec_t vecs[7];
        bit   acc;
        int   k;

        vecs[0] = mk(6'b000000, 5'd4, 5'd1, 32'h0, 5'd5, 32'h0000_00F1, 5'd9,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h0000_00F1, 32'h4, 1'b0);
        vecs[1] = mk(6'b000100, 5'd0, 5'd3, 32'h1, 5'd6, 32'h0000_1234, 5'd10,
                     1'b1, 5'd3, 32'h25, 1'b1, 5'd3, 32'h7,
                     32'h0000_1234, FWD ? 32'h5 : 32'h1, 1'b0);
        vecs[2] = mk(6'b000010, 5'd31, 5'd4, 32'h0, 5'd0, 32'h0, 5'd11,
                     1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'd31, 1'b0);
        vecs[3] = mk(6'b100000, 5'd9, 5'd1, 32'h5, 5'd8, 32'h0000_AAAA, 5'd12,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h0000_AAAA, 32'h0, 1'b1);
        vecs[4] = mk(6'b000111, 5'd0, 5'd2, 32'h3, 5'd2, 32'h8000_0000, 5'd13,
                     1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hFFFF_FF1C,
                     FWD ? 32'hFFFF_FF1C : 32'h8000_0000, FWD ? 32'h1C : 32'h3, 1'b0);
        vecs[5] = mk(6'b000011, 5'd16, 5'd1, 32'h0, 5'd7, 32'h1111_1111, 5'd14,
                     1'b1, 5'd7, 32'hCAFE_0000, 1'b1, 5'd7, 32'h1,
                     FWD ? 32'hCAFE_0000 : 32'h1111_1111, 32'd16, 1'b0);
        vecs[6] = mk(6'b000110, 5'd2, 5'd9, 32'hFFFF_FFE3, 5'd9, 32'h0F0F_0F0F, 5'd15,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h0F0F_0F0F, 32'h3, 1'b0);

        reset = 1'b1; in_valid = 1'b0; sh_ready = 1'b1;
        apply_vec(vecs[0]);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),   64'd1);
        chk("rst_sh_valid",  64'(sh_valid),   64'd0);
        chk("rst_sh_a",      64'(sh_a),       64'd0);
        chk("rst_sh_b",      64'(sh_b),       64'd0);
        chk("rst_sh_sel",    64'(sh_sel),     64'd0);
        chk("rst_sh_rd",     64'(sh_rd),      64'd0);
        chk("rst_sh_illegal",64'(sh_illegal), 64'd0);
        @(posedge clk); #1;

        // Table-driven single instructions, one-cycle latency.
        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i]);
            in_valid = 1'b1; sh_ready = 1'b1;
            cycle_check(acc);
            chk($sformatf("tbl%0d_valid", i), 64'(sh_valid), 64'd1);
            chk($sformatf("tbl%0d_a", i),     64'(sh_a),     64'(vecs[i].exp_a));
            chk($sformatf("tbl%0d_b", i),     64'(sh_b),     64'(vecs[i].exp_b));
            chk($sformatf("tbl%0d_sel", i),   64'(sh_sel),   64'(vecs[i].funct));
            chk($sformatf("tbl%0d_ill", i),   64'(sh_illegal), 64'(vecs[i].exp_ill));
            in_valid = 1'b0;
            cycle_check(acc);
        end

        // Back-to-back I1, I2, I3 against a stalled shifter.
        popped.delete();
        sh_ready = 1'b0;
        apply_vec(mk(6'd0, 5'd1, 5'd0, 32'h0, 5'd4, 32'h100, 5'd1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0));
        in_valid = 1'b1;
        cycle_check(acc);
        in_shamt = 5'd2; in_rt_val = 32'h200; in_rd = 5'd2;
        cycle_check(acc);
        chk("b2b_in_ready_full", 64'(in_ready), 64'd0);
        chk("b2b_hold_I1",       64'(sh_a),     64'h100);
        in_shamt = 5'd3; in_rt_val = 32'h300; in_rd = 5'd3;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 10) begin
            sh_ready = (k >= 2);
            cycle_check(acc);
            k++;
        end
        chk("b2b_I3_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0; sh_ready = 1'b1;
        k = 0;
        while (q.size() > 0 && k < 8) begin
            cycle_check(acc);
            k++;
        end
        chk("b2b_drained", 64'(q.size()), 64'd0);
        chk("b2b_count",   64'(popped.size()), 64'd3);
        for (int i = 0; i < popped.size() && i < 3; i++)
            chk($sformatf("b2b_order%0d", i), 64'(popped[i]), 64'(i + 1));

        // Reset asserted while the buffer is full.
        sh_ready = 1'b0; in_valid = 1'b1; in_rd = 5'd20; in_rt_val = 32'h1234_5678;
        cycle_check(acc);
        in_rd = 5'd21;
        cycle_check(acc);
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_sh_valid", 64'(sh_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_sh_valid", 64'(sh_valid), 64'd0);
        chk("arst_sh_a",     64'(sh_a),     64'd0);
        chk("arst_sh_rd",    64'(sh_rd),    64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_sh_valid", 64'(sh_valid), 64'd0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            sh_ready   = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 7))
                0: in_funct = 6'd0;
                1: in_funct = 6'd2;
                2: in_funct = 6'd3;
                3: in_funct = 6'd4;
                4: in_funct = 6'd6;
                5: in_funct = 6'd7;
                default: in_funct = 6'($urandom);
            endcase
            in_shamt   = 5'($urandom);
            in_rs_idx  = 5'($urandom_range(0, 7));
            in_rt_idx  = 5'($urandom_range(0, 7));
            in_rs_val  = $urandom;
            in_rt_val  = $urandom;
            in_rd      = 5'($urandom);
            exmem_wen  = 1'($urandom);
            exmem_rd   = 5'($urandom_range(0, 7));
            exmem_data = $urandom;
            memwb_wen  = 1'($urandom);
            memwb_rd   = 5'($urandom_range(0, 7));
            memwb_data = $urandom;
            cycle_check(acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
